// File: rtl/uart_word_assembler.sv
// Receive-side word packer: assembles UART bytes LSB-first into words, tags frame
// boundaries, buffers words in a show-ahead FIFO and drops stalled partial frames.
module uart_word_assembler #(
   parameter int REGISTER_SIZE  = 32,
   parameter int BITS_IN_NUM    = 4096,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     valid_in,
   input  logic [7:0]               byte_in,
   input  logic                     consumed_in,
   output logic [REGISTER_SIZE-1:0] data_out,
   output logic                     valid_out,
   output logic                     last_out,
   output logic [15:0]              numbers_done_out,
   output logic                     overflow_out,
   output logic                     timeout_out
);
   localparam int BPW       = REGISTER_SIZE / 8;
   localparam int NUM_WORDS = BITS_IN_NUM / REGISTER_SIZE;
   localparam int BW        = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int PW        = $clog2(FIFO_DEPTH);
   localparam int TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t                   state, state_nxt;
   logic [BW-1:0]            byte_idx;
   logic [WW-1:0]            word_idx;
   logic [REGISTER_SIZE-1:0] word_buf, assembled;
   logic [TW-1:0]            idle_cnt;

   logic [REGISTER_SIZE:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [PW:0]              count;

   logic byte_last, word_last, word_done, frame_done, timeout;
   logic empty, full, pop, push;

   assign byte_last  = (byte_idx == BW'(BPW - 1));
   assign word_last  = (word_idx == WW'(NUM_WORDS - 1));
   assign word_done  = valid_in && byte_last;
   assign frame_done = word_done && word_last;
   // A byte arriving on the expiry cycle wins over the timeout.
   assign timeout    = (state == COLLECT) && !valid_in && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(FIFO_DEPTH));
   assign pop   = consumed_in && !empty;
   assign push  = word_done && (!full || pop);

   always_comb begin
      assembled = word_buf;
      assembled[{byte_idx, 3'b000} +: 8] = byte_in;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid_in && !frame_done) state_nxt = COLLECT;
         COLLECT: if (frame_done || timeout)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= IDLE;
         byte_idx         <= '0;
         word_idx         <= '0;
         word_buf         <= '0;
         idle_cnt         <= '0;
         numbers_done_out <= '0;
         timeout_out      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (timeout) begin
            byte_idx    <= '0;
            word_idx    <= '0;
            word_buf    <= '0;
            timeout_out <= 1'b1;
         end else if (valid_in) begin
            word_buf <= assembled;
            byte_idx <= byte_last ? '0 : byte_idx + BW'(1);
            if (word_done) word_idx <= word_last ? '0 : word_idx + WW'(1);
            if (frame_done) numbers_done_out <= numbers_done_out + 16'd1;
         end
         idle_cnt <= (valid_in || timeout || state != COLLECT) ? '0 : idle_cnt + TW'(1);
      end
   end

   // Word/byte indices advance even when a word is dropped, so framing survives overflow.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_out <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);
         if (word_done && full && !pop) overflow_out <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) mem[wr_ptr] <= {word_last, assembled};
   end

   assign valid_out = !empty;
   assign data_out  = valid_out ? mem[rd_ptr][REGISTER_SIZE-1:0] : '0;
   assign last_out  = valid_out && mem[rd_ptr][REGISTER_SIZE];
endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Receive-side counterpart of the byte_repeater block-to-byte serializer.
- Sits after uart_receive on the decryptor-side link. Packs incoming bytes into REGISTER_SIZE-bit words and frames every BITS_IN_NUM/REGISTER_SIZE words as one ciphertext.
- Buffers completed words in a small show-ahead FIFO for the downstream consumer (SPI controller or redstone_repeater).
- Recovers framing on stalled transfers with an inter-byte timeout.

Parameters:
- REGISTER_SIZE, 32: output word width; must be a multiple of 8.
- BITS_IN_NUM, 4096: bits per ciphertext. NUM_WORDS = BITS_IN_NUM/REGISTER_SIZE (default 128).
- FIFO_DEPTH, 4: completed-word buffer entries; power of 2, ≥2.
- TIMEOUT_CYCLES, 1_000_000: idle clocks mid-frame before the partial frame is discarded.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous active-high reset
- valid_in  input  1  one-cycle pulse; byte_in is valid (uart_receive new_data_out)
- byte_in  input  8  received byte
- consumed_in  input  1  pulse; downstream has taken data_out
- data_out  output  REGISTER_SIZE  head-of-FIFO word
- valid_out  output  1  FIFO not empty
- last_out  output  1  head word is word NUM_WORDS-1 of its ciphertext
- numbers_done_out  output  16  count of completed ciphertext frames; wraps at 2^16
- overflow_out  output  1  sticky: a completed word was dropped
- timeout_out  output  1  sticky: a partial frame was discarded

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset: all outputs are 0. FIFO is empty, byte index = 0, word index = 0, idle counter = 0.
- Packing: byte k of a word (k = 0 .. BYTES_PER_WORD-1, BYTES_PER_WORD = REGISTER_SIZE/8) goes to bits [8k+7:8k]. The first received byte is the LSB byte. This matches byte_repeater send order.
- Word completion is the valid_in cycle carrying byte BYTES_PER_WORD-1. On that edge:
  - the word and its last tag (word index == NUM_WORDS-1) are pushed;
  - byte index returns to 0;
  - word index increments, wrapping NUM_WORDS-1 → 0.
- Frame completion: on the wrap, numbers_done_out increments.
- Latency: with the FIFO empty, valid_out and data_out appear on the cycle after the final byte's valid_in (one cycle).
- FIFO is show-ahead. data_out and last_out are stable while valid_out is high and consumed_in is low.
- Pop: consumed_in with valid_out high pops one entry. consumed_in with valid_out low is ignored.
- Push and pop in the same cycle: both happen; occupancy is unchanged; this is legal when full.
- Full, push with no pop that cycle: the new word is dropped and overflow_out is set. Word and byte indices still advance so frame alignment is kept. FIFO contents are untouched.
- States:
  - IDLE: byte index = 0 and word index = 0.
  - COLLECT: any partial frame.
  - IDLE → COLLECT on any valid_in that does not complete a frame.
  - COLLECT → IDLE on frame completion or timeout.
- Idle counter:
  - counts only in COLLECT;
  - clears on every valid_in;
  - is held at 0 in IDLE.
- Timeout: when the idle counter reaches TIMEOUT_CYCLES-1 with no valid_in that cycle:
  - byte and word indices clear and the partial word is discarded;
  - timeout_out is set and the state returns to IDLE;
  - FIFO contents are kept;
  - numbers_done_out is unchanged.
- valid_in on the exact timeout cycle: the byte is accepted and the timeout does not fire.
- Sticky flags clear only on rst_in.
- Reset mid-frame: everything returns to reset values on the next edge. A byte pulse coincident with rst_in is ignored.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 → one cycle after the 4th byte: data_out = 0x44332211, valid_out = 1, last_out = 0. Hold consumed_in low for 20 cycles → data_out stays stable.
- Stream 512 bytes (byte i = i mod 256) with consumed_in pulsed on each valid_out:
  - 128 words observed; word 0 = 0x03020100;
  - last_out = 1 only on word 127 (0xFFFEFDFC);
  - numbers_done_out = 1.
- Stream 24 bytes with consumed_in held low:
  - FIFO holds words 0–3; words 4 and 5 are dropped;
  - overflow_out = 1;
  - then 4 consumed_in pulses pop words 0–3 in order.
- FIFO full, word completes in the same cycle as consumed_in → no overflow; occupancy stays 4.
- TIMEOUT_CYCLES = 100: send 6 bytes, wait 100 idle cycles → timeout_out = 1 and only word 0 is in the FIFO. Then bytes 0xAA,0xBB,0xCC,0xDD → data word 0xDDCCBBAA, tagged as frame word 0.
- Assert rst_in after 2 bytes of a word → all outputs 0. Next 4 bytes 0x01..0x04 → 0x04030201.
